// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed 7-segment display scanner. It captures a BCD value, a sign
//   flag and a leading-zero-blanking flag into shadow registers on load. One
//   digit is selected at a time, for SCAN_DIV clocks each. A scan-round
//   counter provides the blink timing. All outputs are registered.
//
// Ports
//   clk       in   sole clock, rising edge
//   nreset    in   asynchronous active-low reset
//   load      in   one-cycle strobe that captures value/neg/blank_lz
//   value     in   NDIG BCD digits; digit 0 is in bits [3:0]
//   neg       in   show a minus sign
//   blank_lz  in   blank leading zeros
//   blink_en  in   blink the whole display (used live, not shadowed)
//   seg       out  segments gfedcba, active-low
//   an        out  digit enables, active-low, one-hot-zero
//   ovf       out  the minus sign has no free position
module seg_scan_driver #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLINK_W  = 6
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic              neg,
    input  logic              blank_lz,
    input  logic              blink_en,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              ovf
);

    localparam int IDX_W = $clog2(NDIG);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [4*NDIG-1:0]  val_q, val_d;
    logic               neg_q, neg_d;
    logic               blz_q, blz_d;
    logic [6:0]         seg_q, seg_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic               ovf_q, ovf_d;

    logic               presc_tc;
    logic [IDX_W-1:0]   msd;
    logic [IDX_W:0]     msd_p1;
    logic [3:0]         cur_dig;

    // Scan timing and shadow capture
    always_comb begin
        presc_tc = (presc_q == PRE_LAST);
        presc_d  = presc_tc ? '0 : presc_q + PRE_W'(1);
        idx_d    = idx_q;
        blink_d  = blink_q;
        if (presc_tc) begin
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                blink_d = blink_q + BLINK_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        val_d = load ? value    : val_q;
        neg_d = load ? neg      : neg_q;
        blz_d = load ? blank_lz : blz_q;
    end

    // Most significant nonzero digit and the digit under the current index.
    // Codes 10..15 count as nonzero, so they anchor the MSD while showing blank.
    always_comb begin
        msd     = '0;
        cur_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (val_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
            if (idx_q == IDX_W'(i))      cur_dig = val_q[4*i +: 4];
        end
        // One bit wider so MSD+1 cannot wrap when NDIG is a power of two
        msd_p1 = {1'b0, msd} + (IDX_W+1)'(1);
    end

    // Output decode (registered below)
    always_comb begin
        // The sign only fits when the top position is not a real digit,
        // which in both blanking modes means MSD is below NDIG-1.
        ovf_d = neg_q && (msd == IDX_LAST);
        an_d  = ~(NDIG'(1) << idx_q);
        seg_d = bcd_to_seg(cur_dig);
        if (blz_q && (idx_q > msd)) seg_d = SEG_BLANK;
        if (neg_q && !ovf_d) begin
            if (blz_q && ({1'b0, idx_q} == msd_p1)) seg_d = SEG_MINUS;
            if (!blz_q && (idx_q == IDX_LAST))      seg_d = SEG_MINUS;
        end
        if (blink_en && blink_q[BLINK_W-1]) seg_d = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            val_q   <= '0;
            neg_q   <= 1'b0;
            blz_q   <= 1'b1;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            val_q   <= val_d;
            neg_q   <= neg_d;
            blz_q   <= blz_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            ovf_q   <= ovf_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with NDIG=4, SCAN_DIV=4, BLINK_W=2.
// Each row describes one 16-clock scan round: the shadow contents loaded at
// the end of the previous round, the blink enable, and the hand-computed
// segment pattern for digits 0..3. Expectations are queued per round; a
// monitor pops one whenever the digit enables change (or a reset sample is
// requested) and compares an/seg/ovf.
module tb_seg_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0011000, SB = 7'b1111111, SM = 7'b0111111;
    localparam int NROWS = 17;

    logic        clk;
    logic        nreset;
    logic        load;
    logic [15:0] value;
    logic        neg;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ovf;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ovf;
        string      name;
    } exp_t;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic        ng;
        logic        blz;
        logic        bl;
        logic        rst;
        logic [27:0] segs;   // {d3, d2, d1, d0}
        logic        ovf;
    } row_t;

    exp_t exp_q[$];
    row_t rows[NROWS];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic sample_req;

    seg_scan_driver #(
        .NDIG     (4),
        .SCAN_DIV (4),
        .BLINK_W  (2)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .load     (load),
        .value    (value),
        .neg      (neg),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .seg      (seg),
        .an       (an),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] a, input logic [6:0] s,
                            input logic o, input string nm);
        exp_t e;
        e.an   = a;
        e.seg  = s;
        e.ovf  = o;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic add_row(input int k, input logic ld, input logic [15:0] val,
                           input logic ng, input logic blz, input logic bl,
                           input logic rst, input logic [27:0] segs,
                           input logic o);
        rows[k].ld   = ld;
        rows[k].val  = val;
        rows[k].ng   = ng;
        rows[k].blz  = blz;
        rows[k].bl   = bl;
        rows[k].rst  = rst;
        rows[k].segs = segs;
        rows[k].ovf  = o;
    endtask

    // Monitor: one comparison per digit-enable change or reset sample
    initial begin
        logic [3:0] prev_an;
        exp_t       e;
        prev_an = 4'b1111;
        forever begin
            @(negedge clk);
            if ((an !== prev_an) || sample_req) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: an=%b seg=%b ovf=%b with nothing expected",
                             an, seg, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if ({an, seg, ovf} !== {e.an, e.seg, e.ovf}) begin
                        n_fail++;
                        $display("FAIL %s: got an=%b seg=%b ovf=%b, expected an=%b seg=%b ovf=%b",
                                 e.name, an, seg, ovf, e.an, e.seg, e.ovf);
                    end
                end
            end
            prev_an = an;
        end
    end

    // Called at the falling edge just before the first clock of a round
    task automatic run_row(input int k);
        int ndig;
        ndig = rows[k].rst ? 3 : 4;
        for (int d = 0; d < ndig; d++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << d;
            push_exp(~onehot, rows[k].segs[7*d +: 7], rows[k].ovf,
                     $sformatf("row%0d_dig%0d", k, d));
        end
        blink_en = rows[k].bl;
        if (rows[k].rst) begin
            // Digit 2 is on screen; reset between clock edges
            repeat (10) @(posedge clk);
            #1;
            push_exp(4'b1111, SB, 1'b0, "reset_mid_scan");
            sample_req = 1'b1;
            nreset     = 1'b0;
            @(negedge clk);
            #1 sample_req = 1'b0;
            @(negedge clk);
            @(negedge clk);
            nreset = 1'b1;
        end else begin
            repeat (15) @(negedge clk);
            // Load lands on the prescaler terminal count of digit 3
            if ((k + 1 < NROWS) && rows[k+1].ld) begin
                value    = rows[k+1].val;
                neg      = rows[k+1].ng;
                blank_lz = rows[k+1].blz;
                load     = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    initial begin
        nreset     = 1'b1;
        load       = 1'b0;
        value      = '0;
        neg        = 1'b0;
        blank_lz   = 1'b0;
        blink_en   = 1'b0;
        sample_req = 1'b0;

        //          k  ld   value    ng   blz  bl   rst  {d3,d2,d1,d0}     ovf
        add_row( 0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, {SB, SB, SB, S0}, 1'b0);
        add_row( 1, 1'b1, 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0, {SB, SM, S4, S2}, 1'b0);
        add_row( 2, 1'b1, 16'h9042, 1'b1, 1'b1, 1'b0, 1'b0, {S9, S0, S4, S2}, 1'b1);
        add_row( 3, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0, {S0, S0, SB, S5}, 1'b0);
        add_row( 4, 1'b1, 16'h0305, 1'b1, 1'b0, 1'b0, 1'b0, {SM, S3, S0, S5}, 1'b0);
        add_row( 5, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, {S1, S0, S0, S0}, 1'b1);
        add_row( 6, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, {SB, SB, SM, S0}, 1'b0);
        add_row( 7, 1'b1, 16'h6789, 1'b0, 1'b1, 1'b0, 1'b0, {S6, S7, S8, S9}, 1'b0);
        add_row( 8, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, {S6, S7, S8, S9}, 1'b0);
        add_row( 9, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, {S6, S7, S8, S9}, 1'b0);
        add_row(10, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, {SB, SB, SB, SB}, 1'b0);
        add_row(11, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, {SB, SB, SB, SB}, 1'b0);
        add_row(12, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, {S6, S7, S8, S9}, 1'b0);
        add_row(13, 1'b1, 16'h0D21, 1'b0, 1'b1, 1'b0, 1'b0, {SB, SB, S2, S1}, 1'b0);
        add_row(14, 1'b1, 16'h0357, 1'b0, 1'b1, 1'b0, 1'b1, {SB, S3, S5, S7}, 1'b0);
        add_row(15, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, {SB, SB, SB, S0}, 1'b0);
        add_row(16, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, {S0, S0, S4, S2}, 1'b0);

        #1 nreset = 1'b0;
        #1;
        push_exp(4'b1111, SB, 1'b0, "reset_initial");
        sample_req = 1'b1;
        @(negedge clk);
        #1 sample_req = 1'b0;
        @(negedge clk);
        nreset = 1'b1;

        for (int k = 0; k < NROWS; k++) run_row(k);

        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_expectations: %0d still queued, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit stays selected (>=2).
REQ-003 SHALL have parameter BLINK_W, default 6, width of the scan-round counter that sets blink period.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port nreset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value/neg/blank_lz.
REQ-007 SHALL have port value  input  4*NDIG  BCD digits, digit 0 in bits [3:0] (least significant).
REQ-008 SHALL have port neg  input  1  show minus sign when 1.
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port blink_en  input  1  blink whole display, sampled live.
REQ-011 SHALL have port seg  output  7  segments gfedcba, active-low.
REQ-012 SHALL have port an  output  NDIG  digit enables, active-low, one-hot-zero.
REQ-013 SHALL have port ovf  output  1  sign could not be placed.

Function
REQ-014 SHALL capture value, neg, blank_lz into shadow registers on the clk edge where load=1; display uses shadow only.
REQ-015 SHALL run prescaler 0..SCAN_DIV-1; on terminal count, digit index advances, wrapping NDIG-1 -> 0.
REQ-016 SHALL increment blink counter (BLINK_W bits, wrapping) each time digit index wraps to 0.
REQ-017 SHALL register seg and an; both reflect current index and shadow one cycle after either changes (load at edge t -> seg valid after edge t+1).
REQ-018 SHALL drive an[index]=0, all other an bits 1.
REQ-019 SHALL decode BCD 0..9 as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
REQ-020 SHALL output blank (1111111) for digit codes 10..15.
REQ-021 SHALL define MSD as highest digit position with nonzero code; MSD=0 when all digits zero.
REQ-022 SHALL, when shadow blank_lz=1, blank positions above MSD; position 0 never blanked by LZ rule.
REQ-023 SHALL, when shadow neg=1 and blank_lz=1 and MSD<NDIG-1, show minus (0111111) at position MSD+1.
REQ-024 SHALL, when shadow neg=1 and blank_lz=0, show minus at position NDIG-1 overriding its digit if that digit is zero; else ovf=1.
REQ-025 SHALL set ovf=1 when shadow neg=1 and no position is available per REQ-023/024 (MSD=NDIG-1); digits then display unchanged without sign.
REQ-026 SHALL, when blink_en=1 and blink counter MSB=1, force seg=1111111 while an keeps scanning.
REQ-027 SHALL keep ovf registered, updated the cycle after shadow changes.
REQ-028 SHALL, on load coinciding with prescaler terminal count, apply both: new shadow and new index visible together one cycle later.

Reset
REQ-029 SHALL, while nreset=0, force seg=1111111, an all 1, ovf=0, prescaler=0, index=0, blink counter=0, shadow value=0, neg=0, blank_lz=1.
REQ-030 SHALL, after nreset release, drive an[0]=0 and seg=1000000 after first clk edge.
REQ-031 SHALL, on reset assertion mid-scan, return outputs to reset values immediately, without waiting for clk.

Verification
REQ-032 NDIG=4, SCAN_DIV=4: reset release, no load -> an cycles 1110,1101,1011,0111 every 4 clk; seg=1000000 on an=1110, 1111111 elsewhere.
REQ-033 load value=16'h0042, neg=1, blank_lz=1 -> digit0 0100100, digit1 0011001, digit2 0111111, digit3 1111111, ovf=0.
REQ-034 load value=16'h9042, neg=1, blank_lz=1 -> ovf=1, digits show 9,0,4,2, no minus.
REQ-035 load value=16'h00A5, blank_lz=0 -> digit1 blank, digit0 0010010, digits 2,3 show 1000000.
REQ-036 BLINK_W=2, blink_en=1 -> seg all 1 during scan rounds 2,3 of each 4; an unchanged.
REQ-037 nreset pulsed low mid-digit-2 -> seg=1111111, an=1111 asynchronously; after release scan restarts at digit 0 with value 0.
